instr_queue: RTL and testbench

//  Decoupling instruction queue between fetch and decode; receiver of fetch's pcF/instrF and sole driver of its stallF.

---
 rtl/instr_queue_pkg.sv | 14 +
 rtl/instr_queue_mem.sv | 29 ++
 rtl/instr_queue.sv | 90 +++++++++
 tb/tb_instr_queue.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_queue_pkg.sv
// Shared widths, the empty-head instruction encoding and the storage entry layout
// for the fetch/decode instruction queue.
package instr_queue_pkg;

    localparam int          WORD_WIDTH = 32;
    localparam logic [31:0] INSTR_NOP  = 32'h0000_0000;

    // Stored word is {pc, instr}: pc occupies bits [63:32].
    typedef struct packed {
        logic [WORD_WIDTH-1:0] pc;
        logic [WORD_WIDTH-1:0] instr;
    } entry_t;

endpackage

// File: rtl/instr_queue_mem.sv
// Entry storage for the instruction queue: one synchronous write port and
// one asynchronous read port that feeds the queue head.
module instr_queue_mem
    import instr_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  entry_t            wdata,
    input  logic [ADDR_W-1:0] raddr,
    output entry_t            rdata
);

    entry_t storage [DEPTH];

    // NOTE: storage has no reset on purpose; only the queue's count decides
    // which entries are meaningful, so stale data is never observed.
    always_ff @(posedge clk) begin
        if (we) begin
            storage[waddr] <= wdata;
        end
    end

    assign rdata = storage[raddr];

endmodule

// File: rtl/instr_queue.sv
// Decoupling queue between fetch and decode: captures one {pc, instr} pair per
// unstalled cycle, presents the oldest to decode, back-pressures fetch when full.
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] pcF,
    input  logic [WORD_WIDTH-1:0] instrF,
    input  logic                  stallD,
    input  logic                  flushD,
    output logic                  stallF,
    output logic                  validD,
    output logic [WORD_WIDTH-1:0] pcD,
    output logic [WORD_WIDTH-1:0] instrD
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              enq;
    logic              deq;
    entry_t            wr_entry;
    entry_t            head;

    // Both flags come from registered count only, so decode-side inputs never
    // reach stallF combinationally.
    assign stallF = (count == FULL_COUNT);
    assign validD = (count != '0);

    assign enq = !stallF && !flushD;
    assign deq = validD && !stallD && !flushD;

    assign wr_entry = '{pc: pcF, instr: instrF};

    instr_queue_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (enq),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flushD) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            unique case ({enq, deq})
                2'b10:   count <= count + (ADDR_W + 1)'(1);
                2'b01:   count <= count - (ADDR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: outputs get a default before the conditional override so the
    // empty case cannot infer a latch.
    always_comb begin
        pcD    = '0;
        instrD = INSTR_NOP;
        if (validD) begin
            pcD    = head.pc;
            instrD = head.instr;
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_instr_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pcF = '0;
    logic [31:0] instrF = '0;
    logic        stallD = 1'b0;
    logic        flushD = 1'b0;
    logic        stallF;
    logic        validD;
    logic [31:0] pcD;
    logic [31:0] instrD;

    instr_queue #(.DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .pcF    (pcF),
        .instrF (instrF),
        .stallD (stallD),
        .flushD (flushD),
        .stallF (stallF),
        .validD (validD),
        .pcD    (pcD),
        .instrD (instrD)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        model_q[$];
    bit          live = 0;
    logic [31:0] fetch_pc = '0;
    bit          in_stream = 0;
    int          wraps = 0;
    logic [1:0]  prev_wr = '0;

    function automatic logic [31:0] mk_instr(input logic [31:0] pc);
        return {pc[23:0], 8'h13};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of pairs obeying the enqueue/dequeue/flush rules.
    always @(posedge clk) begin
        automatic bit full  = (model_q.size() == DEPTH);
        automatic bit empty = (model_q.size() == 0);
        if (rst || flushD) begin
            model_q.delete();
        end else begin
            if (!empty && !stallD) void'(model_q.pop_front());
            if (!full) model_q.push_back('{pc: pcF, instr: instrF});
        end
        live = 1;
        if (dut.count > DEPTH) begin
            errors++;
            $display("FAIL count_bound: got %0d expected <= %0d", dut.count, DEPTH);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (live) begin
            automatic bit          exp_valid = (model_q.size() != 0);
            automatic logic [31:0] exp_pc    = exp_valid ? model_q[0].pc : 32'h0;
            automatic logic [31:0] exp_instr = exp_valid ? model_q[0].instr : 32'h0;
            check("validD", {31'b0, validD}, {31'b0, exp_valid});
            check("stallF", {31'b0, stallF}, {31'b0, model_q.size() == DEPTH});
            check("pcD", pcD, exp_pc);
            check("instrD", instrD, exp_instr);
        end
        if (in_stream && prev_wr == 2'(DEPTH - 1) && dut.wr_ptr == 2'd0) wraps++;
        prev_wr = dut.wr_ptr;
    end

    // Fetch stand-in: presents fetch_pc every cycle; pc advances iff not stalled.
    task automatic tick(input logic sd, input logic fl);
        automatic bit adv;
        stallD = sd;
        flushD = fl;
        pcF    = fetch_pc;
        instrF = mk_instr(fetch_pc);
        adv    = !stallF;
        @(posedge clk);
        if (adv) fetch_pc = fetch_pc + 32'd4;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] dec[$];
        int          cyc;
        logic        sd;

        // 1. Reset, then a short unstalled stream.
        rst = 1'b1;
        tick(0, 0);
        tick(0, 0);
        check("rst_validD", {31'b0, validD}, 32'd0);
        check("rst_stallF", {31'b0, stallF}, 32'd0);
        check("rst_pcD", pcD, 32'h0);
        check("rst_instrD", instrD, 32'h0);
        rst = 1'b0;
        fetch_pc = 32'h0;
        tick(0, 0);
        check("t1_pc0", pcD, 32'h0);
        tick(0, 0);
        check("t1_pc4", pcD, 32'h4);
        check("t1_instr4", instrD, 32'h0000_0413);
        tick(0, 0);
        check("t1_pc8", pcD, 32'h8);

        // 2 & 4. Fill while decode stalls, then drain with full-and-deq.
        fetch_pc = 32'hF00;
        tick(0, 1);
        fetch_pc = 32'h100;
        for (int k = 0; k < 4; k++) tick(1, 0);
        check("t2_full", {31'b0, stallF}, 32'd1);
        check("t2_head", pcD, 32'h100);
        tick(1, 0);
        check("t2_held_pc", fetch_pc, 32'h110);
        tick(0, 0);
        check("t4_unstall", {31'b0, stallF}, 32'd0);
        check("t4_head", pcD, 32'h104);
        tick(0, 0);
        check("t2_pc108", pcD, 32'h108);
        tick(0, 0);
        check("t2_pc10c", pcD, 32'h10C);
        tick(0, 0);
        check("t2_pc110", pcD, 32'h110);
        tick(0, 0);
        check("t4_pc114", pcD, 32'h114);

        // 3. Flush with three entries held and decode stalled.
        fetch_pc = 32'h200;
        tick(1, 1);
        check("t3_validD", {31'b0, validD}, 32'd0);
        check("t3_stallF", {31'b0, stallF}, 32'd0);
        check("t3_instrD", instrD, 32'h0);
        fetch_pc = 32'h400;
        tick(0, 0);
        check("t3_pc400", pcD, 32'h400);
        check("t3_instr400", instrD, 32'h0004_0013);

        // 5. Twenty instructions with random decode stalls.
        fetch_pc = 32'hDEAD_0000;
        tick(0, 1);
        fetch_pc = 32'h1000;
        in_stream = 1;
        cyc = 0;
        while (dec.size() < 20 && cyc < 300) begin
            sd = 1'($urandom_range(0, 1));
            if (validD && !sd) dec.push_back(pcD);
            tick(sd, 0);
            cyc++;
        end
        in_stream = 0;
        check("t5_decoded", dec.size(), 32'd20);
        foreach (dec[k]) check("t5_order", dec[k], 32'h1000 + 32'(4 * k));
        check("t5_wraps_ge4", {31'b0, wraps >= 4}, 32'd1);

        // 6. Reset while full and stalled, then resume.
        fetch_pc = 32'h600;
        tick(1, 1);
        fetch_pc = 32'h600;
        for (int k = 0; k < 4; k++) tick(1, 0);
        check("t6_full", {31'b0, stallF}, 32'd1);
        rst = 1'b1;
        tick(1, 0);
        rst = 1'b0;
        check("t6_validD", {31'b0, validD}, 32'd0);
        check("t6_stallF", {31'b0, stallF}, 32'd0);
        check("t6_pcD", pcD, 32'h0);
        fetch_pc = 32'h800;
        tick(0, 0);
        check("t6_pc800", pcD, 32'h800);
        tick(0, 0);
        check("t6_pc804", pcD, 32'h804);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
